nibble_serial_addsub_ctrl: RTL and testbench

//  Sequences one shared 4-bit carry-lookahead slice to add or subtract operands of NIBBLES*4 bits.

---
 rtl/nibble_serial_addsub_ctrl.sv | 151 +++++++++++++++
 tb/tb_nibble_serial_addsub_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_addsub_ctrl.sv
// nibble_serial_addsub_ctrl
//   Adds or subtracts two NIBBLES*4-bit operands with one shared 4-bit
//   carry-lookahead slice. The operation runs one nibble per clock, LSB
//   first, and a register carries the slice carry-out into the next nibble.
//   Subtraction is computed as A + ~B + 1: B is inverted when it is latched
//   and the initial carry is set to 1.
//
// Ports
//   clk       in   1  clock, rising edge
//   rst       in   1  synchronous reset, active-high
//   start     in   1  request, accepted only while ready=1
//   sub       in   1  0 = A+B, 1 = A-B (sampled with start)
//   a, b      in   W  operands (sampled with start)
//   ready     out  1  high in IDLE
//   busy      out  1  high in RUN
//   nib_idx   out  4  nibble currently being processed
//   result    out  W  sum/difference, stable while valid=1
//   cout      out  1  final carry (for sub: 1 = no borrow)
//   overflow  out  1  two's-complement overflow of result
//   valid     out  1  result/cout/overflow valid (DONE state)
//   ack       in   1  consumer accepts result while valid=1
module nibble_serial_addsub_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 ready,
  output logic                 busy,
  output logic [3:0]           nib_idx,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 overflow,
  output logic                 valid,
  input  logic                 ack
);

  localparam int unsigned W = 4 * NIBBLES;
  localparam logic [3:0]  LAST_IDX = 4'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;      // already inverted for subtraction
  logic           r_carry;
  logic [3:0]     r_idx;
  logic [W-1:0]   r_result;
  logic           r_cout;
  logic           r_ovf;

  logic [3:0]     w_a_nib;
  logic [3:0]     w_b_nib;
  logic [3:0]     w_p;
  logic [3:0]     w_g;
  logic [3:0]     w_c;      // carry into each bit of the slice
  logic           w_cout;
  logic [3:0]     w_sum;

  // Select the operand nibbles addressed by r_idx.
  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (r_idx == 4'(i)) begin
        w_a_nib = r_a[4*i +: 4];
        w_b_nib = r_b[4*i +: 4];
      end
    end
  end

  // Shared 4-bit carry-lookahead slice: every carry is a flat sum of
  // products of G, P and Cin rather than a ripple chain.
  always_comb begin
    w_p    = w_a_nib ^ w_b_nib;
    w_g    = w_a_nib & w_b_nib;
    w_c[0] = r_carry;
    w_c[1] = w_g[0] | (w_p[0] & r_carry);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & r_carry);
    w_cout = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
    w_sum  = w_p ^ w_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b ^ {W{sub}};
            r_carry  <= sub;
            r_idx    <= '0;
            r_result <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (r_idx == 4'(i)) begin
              r_result[4*i +: 4] <= w_sum;
            end
          end
          r_carry <= w_cout;
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_cout;
            r_ovf   <= w_c[3] ^ w_cout;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        S_DONE: begin
          // start is ignored here even when it coincides with ack.
          if (ack) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready    = (r_state == S_IDLE);
  assign busy     = (r_state == S_RUN);
  assign valid    = (r_state == S_DONE);
  assign nib_idx  = r_idx;
  assign result   = r_result;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
module tb_nibble_serial_addsub_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        ready;
  logic        busy;
  logic [3:0]  nib_idx;
  logic [15:0] result;
  logic        cout;
  logic        overflow;
  logic        valid;
  logic        ack;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        v;
  } exp_t;

  exp_t sb_q[$];

  nibble_serial_addsub_ctrl #(.NIBBLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .busy     (busy),
    .nib_idx  (nib_idx),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .valid    (valid),
    .ack      (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t ref_model(input logic [15:0] ra, input logic [15:0] rb, input logic rs);
    exp_t        e;
    logic [15:0] bb;
    logic [16:0] full;
    bb    = rs ? ~rb : rb;
    full  = {1'b0, ra} + {1'b0, bb} + {16'd0, rs};
    e.res = full[15:0];
    e.c   = full[16];
    e.v   = (ra[15] == bb[15]) && (full[15] != ra[15]);
    return e;
  endfunction

  // One complete transaction: issue, check latency, compare against the
  // scoreboard entry, acknowledge after ack_delay cycles.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                       input exp_t e, input int ack_delay);
    int   n;
    exp_t got;
    n = 0;
    while (ready !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: ready=%b required 1", ready);
    end
    a = ta; b = tb_v; sub = ts; start = 1'b1;
    sb_q.push_back(e);
    tick();
    start = 1'b0;
    // Operands must have been latched; scramble the inputs.
    a = ~ta; b = ~tb_v; sub = ~ts;
    checks++;
    if (busy !== 1'b1 || nib_idx !== 4'd0) begin
      errors++;
      $display("FAIL accept: busy=%b nib_idx=%0d required busy=1 nib_idx=0", busy, nib_idx);
    end
    n = 0;
    while (valid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL latency: edges=%0d required 4", n);
    end
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: size=0 required >0");
    end else begin
      got = sb_q.pop_front();
      if (result !== got.res || cout !== got.c || overflow !== got.v) begin
        errors++;
        $display("FAIL result a=%h b=%h sub=%b: got res=%h cout=%b ovf=%b required res=%h cout=%b ovf=%b",
                 ta, tb_v, ts, result, cout, overflow, got.res, got.c, got.v);
      end
    end
    repeat (ack_delay) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL ack_return: valid=%b ready=%b required valid=0 ready=1", valid, ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || valid !== 1'b0 || nib_idx !== 4'd0 ||
        result !== 16'h0000 || cout !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset: ready=%b busy=%b valid=%b idx=%0d res=%h cout=%b ovf=%b required 1 0 0 0 0000 0 0",
               ready, busy, valid, nib_idx, result, cout, overflow);
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    do_op(16'h1234, 16'h0FFF, 1'b0, '{res: 16'h2233, c: 1'b0, v: 1'b0}, 0);
  endtask

  task automatic test_carry_chain();
    do_op(16'hFFFF, 16'h0001, 1'b0, '{res: 16'h0000, c: 1'b1, v: 1'b0}, 1);
    do_op(16'h7FFF, 16'h0001, 1'b0, '{res: 16'h8000, c: 1'b0, v: 1'b1}, 0);
  endtask

  task automatic test_sub();
    do_op(16'h0005, 16'h0007, 1'b1, '{res: 16'hFFFE, c: 1'b0, v: 1'b0}, 2);
    do_op(16'h8000, 16'h0001, 1'b1, '{res: 16'h7FFF, c: 1'b1, v: 1'b1}, 0);
  endtask

  task automatic test_handshake();
    int n;
    a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    a = 16'hFFFF; b = 16'hFFFF;
    tick();
    start = 1'b1; sub = 1'b1;        // pulse during RUN
    tick();
    start = 1'b0;
    n = 0;
    while (valid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (valid !== 1'b1 || result !== 16'h3333 || cout !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL hs_result: valid=%b res=%h cout=%b ovf=%b required 1 3333 0 0", valid, result, cout, overflow);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (valid !== 1'b1 || result !== 16'h3333 || cout !== 1'b0 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL hs_hold cycle %0d: valid=%b res=%h required valid=1 res=3333", i, valid, result);
      end
    end
    start = 1'b1;                    // pulse during DONE without ack
    tick();
    start = 1'b0;
    checks++;
    if (valid !== 1'b1 || busy !== 1'b0 || result !== 16'h3333) begin
      errors++;
      $display("FAIL hs_start_done: valid=%b busy=%b res=%h required 1 0 3333", valid, busy, result);
    end
    start = 1'b1; ack = 1'b1;        // ack and start together
    tick();
    start = 1'b0; ack = 1'b0;
    checks++;
    if (ready !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL hs_ack_start: ready=%b valid=%b required ready=1 valid=0", ready, valid);
    end
    tick();
    tick();
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL hs_no_new_op: ready=%b busy=%b valid=%b required 1 0 0", ready, busy, valid);
    end
  endtask

  task automatic test_reset_mid_op();
    int n;
    a = 16'h1234; b = 16'h0FFF; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (nib_idx !== 4'd2 && n < 10) begin tick(); n++; end
    checks++;
    if (nib_idx !== 4'd2 || busy !== 1'b1 || result !== 16'h0033) begin
      errors++;
      $display("FAIL partial: idx=%0d busy=%b res=%h required idx=2 busy=1 res=0033", nib_idx, busy, result);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || valid !== 1'b0 || result !== 16'h0000 || nib_idx !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid: ready=%b busy=%b valid=%b res=%h idx=%0d required 1 0 0 0000 0",
               ready, busy, valid, result, nib_idx);
    end
    do_op(16'h1234, 16'h0FFF, 1'b0, '{res: 16'h2233, c: 1'b0, v: 1'b0}, 0);
  endtask

  task automatic test_back_to_back();
    do_op(16'h0F0F, 16'h00F1, 1'b0, ref_model(16'h0F0F, 16'h00F1, 1'b0), 0);
    do_op(16'h0000, 16'h0000, 1'b1, '{res: 16'h0000, c: 1'b1, v: 1'b0}, 0);
    do_op(16'h8000, 16'h8000, 1'b0, '{res: 16'h0000, c: 1'b1, v: 1'b1}, 0);
  endtask

  task automatic test_random();
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      do_op(ra, rb, rs, ref_model(ra, rb, rs), int'($urandom_range(0, 5)));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; ack = 1'b0;
    test_reset();
    test_add();
    test_carry_chain();
    test_sub();
    test_handshake();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
